// File: rtl/lcd_spi_pkg.sv
// rtl/lcd_spi_pkg.sv - shared opcodes and decoder state type for the LCD SPI responder
package lcd_spi_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [1:0] {IDLE, PARAM, PIX_HI, PIX_LO} lcd_rx_state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// rtl/spi_byte_rx.sv - oversampling SPI mode-0 byte receiver (sync, SCK edge detect, shift register)
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cs_i,
  input  logic       dcrs_i,
  input  logic       sdi_i,
  input  logic       sck_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       dc_o
);

  logic [SYNC_STAGES-1:0] cs_sync_q, dc_sync_q, sdi_sync_q, sck_sync_q;
  logic                   sck_prev_q;
  logic [2:0]             bit_cnt_q;
  logic [6:0]             shift_q;
  logic                   valid_q;
  logic [7:0]             byte_q;
  logic                   dc_q;

  logic cs_s, dc_s, sdi_s, sck_s, sck_rise;

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign dc_s     = dc_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  // All four lines share the same synchroniser depth, so SDI keeps its setup relative to SCK.
  assign sck_rise = sck_s & ~sck_prev_q & ~cs_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cs_sync_q  <= '1;
      dc_sync_q  <= '0;
      sdi_sync_q <= '0;
      sck_sync_q <= '0;
      sck_prev_q <= 1'b0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      valid_q    <= 1'b0;
      byte_q     <= 8'd0;
      dc_q       <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      dc_sync_q  <= {dc_sync_q[SYNC_STAGES-2:0], dcrs_i};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      sck_prev_q <= sck_s;
      valid_q    <= 1'b0;
      // Deselect drops any partial byte; the counter restarts on the next select.
      if (cs_s) begin
        bit_cnt_q <= 3'd0;
      end else if (sck_rise) begin
        shift_q   <= {shift_q[5:0], sdi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          valid_q <= 1'b1;
          byte_q  <= {shift_q, sdi_s};
          dc_q    <= dc_s;
        end
      end
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_o       = byte_q;
  assign dc_o         = dc_q;

endmodule

// File: rtl/lcd_spi_responder.sv
// rtl/lcd_spi_responder.sv - LCD-side SPI command decoder with address window and pixel stream output
module lcd_spi_responder
  import lcd_spi_pkg::*;
#(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk_100MHz,
  input  logic        i_rst_n,
  input  logic        i_cs,
  input  logic        i_dcrs,
  input  logic        i_sdi,
  input  logic        i_sck,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd,
  output logic        o_pix_valid,
  output logic [15:0] o_pix_data,
  output logic [8:0]  o_x,
  output logic [7:0]  o_y,
  output logic        o_frame_start,
  output logic        o_frame_done,
  output logic        o_err
);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_dc;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
    .clk_i        (i_clk_100MHz),
    .rst_ni       (i_rst_n),
    .cs_i         (i_cs),
    .dcrs_i       (i_dcrs),
    .sdi_i        (i_sdi),
    .sck_i        (i_sck),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .dc_o         (rx_dc)
  );

  lcd_rx_state_t state_q, state_d;
  logic [1:0]  pcnt_q, pcnt_d;
  logic        is_y_q, is_y_d;
  logic [7:0]  p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, hi_q, hi_d;
  logic [8:0]  xs_q, xs_d, xe_q, xe_d, x_q, x_d, ox_q, ox_d;
  logic [7:0]  ys_q, ys_d, ye_q, ye_d, y_q, y_d, oy_q, oy_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] pix_q, pix_d;
  logic        cmd_v_q, cmd_v_d, pix_v_q, pix_v_d, fs_q, fs_d, fd_q, fd_d, err_q, err_d;

  logic [15:0] s_val, e_val, limit;
  logic        win_ok;

  // Window bounds are judged on the full 16-bit values before truncation to register width.
  assign s_val  = {p0_q, p1_q};
  assign e_val  = {p2_q, rx_byte};
  assign limit  = is_y_q ? 16'(HEIGHT) : 16'(WIDTH);
  assign win_ok = (s_val <= e_val) && (e_val < limit);

  always_ff @(posedge i_clk_100MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pcnt_q  <= 2'd0;
      is_y_q  <= 1'b0;
      p0_q    <= 8'd0;
      p1_q    <= 8'd0;
      p2_q    <= 8'd0;
      hi_q    <= 8'd0;
      xs_q    <= 9'd0;
      xe_q    <= 9'(WIDTH - 1);
      ys_q    <= 8'd0;
      ye_q    <= 8'(HEIGHT - 1);
      x_q     <= 9'd0;
      y_q     <= 8'd0;
      ox_q    <= 9'd0;
      oy_q    <= 8'd0;
      cmd_q   <= 8'h00;
      pix_q   <= 16'h0000;
      cmd_v_q <= 1'b0;
      pix_v_q <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      is_y_q  <= is_y_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      hi_q    <= hi_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ys_q    <= ys_d;
      ye_q    <= ye_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      cmd_q   <= cmd_d;
      pix_q   <= pix_d;
      cmd_v_q <= cmd_v_d;
      pix_v_q <= pix_v_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    is_y_d  = is_y_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    hi_d    = hi_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    ys_d    = ys_q;
    ye_d    = ye_q;
    x_d     = x_q;
    y_d     = y_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    cmd_d   = cmd_q;
    pix_d   = pix_q;
    cmd_v_d = 1'b0;
    pix_v_d = 1'b0;
    fs_d    = 1'b0;
    fd_d    = 1'b0;
    err_d   = 1'b0;

    if (rx_valid && !rx_dc) begin
      cmd_v_d = 1'b1;
      cmd_d   = rx_byte;
      pcnt_d  = 2'd0;
      if (rx_byte == CMD_CASET || rx_byte == CMD_PASET) begin
        state_d = PARAM;
        is_y_d  = (rx_byte == CMD_PASET);
      end else if (rx_byte == CMD_RAMWR) begin
        state_d = PIX_HI;
        x_d     = xs_q;
        y_d     = ys_q;
        fs_d    = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else if (rx_valid) begin
      unique case (state_q)
        PARAM: begin
          pcnt_d = pcnt_q + 2'd1;
          unique case (pcnt_q)
            2'd0: p0_d = rx_byte;
            2'd1: p1_d = rx_byte;
            2'd2: p2_d = rx_byte;
            default: begin
              state_d = IDLE;
              if (!win_ok) begin
                err_d = 1'b1;
              end else if (is_y_q) begin
                ys_d = s_val[7:0];
                ye_d = e_val[7:0];
              end else begin
                xs_d = s_val[8:0];
                xe_d = e_val[8:0];
              end
            end
          endcase
        end
        PIX_HI: begin
          hi_d    = rx_byte;
          state_d = PIX_LO;
        end
        PIX_LO: begin
          pix_v_d = 1'b1;
          pix_d   = {hi_q, rx_byte};
          ox_d    = x_q;
          oy_d    = y_q;
          state_d = PIX_HI;
          if (x_q == xe_q) begin
            x_d = xs_q;
            if (y_q == ye_q) begin
              y_d  = ys_q;
              fd_d = 1'b1;
            end else begin
              y_d = y_q + 8'd1;
            end
          end else begin
            x_d = x_q + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_valid   = cmd_v_q;
  assign o_cmd         = cmd_q;
  assign o_pix_valid   = pix_v_q;
  assign o_pix_data    = pix_q;
  assign o_x           = ox_q;
  assign o_y           = oy_q;
  assign o_frame_start = fs_q;
  assign o_frame_done  = fd_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_lcd_spi_responder.sv
// tb/tb_lcd_spi_responder.sv - scoreboard bench for the LCD SPI responder
module tb_lcd_spi_responder;

  typedef struct packed {
    logic [15:0] d;
    logic [8:0]  x;
    logic [7:0]  y;
    logic        done;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b1, dcrs = 1'b0, sdi = 1'b0, sck = 1'b0;
  logic        o_cmd_valid, o_pix_valid, o_frame_start, o_frame_done, o_err;
  logic [7:0]  o_cmd;
  logic [15:0] o_pix_data;
  logic [8:0]  o_x;
  logic [7:0]  o_y;

  int checks = 0;
  int failures = 0;
  pix_t exp_q[$];
  pix_t obs_q[$];
  int cmd_cnt = 0, fs_cnt = 0, err_cnt = 0, stray_done = 0;

  always #5 clk = ~clk;

  lcd_spi_responder dut (
    .i_clk_100MHz  (clk),
    .i_rst_n       (rst_n),
    .i_cs          (cs),
    .i_dcrs        (dcrs),
    .i_sdi         (sdi),
    .i_sck         (sck),
    .o_cmd_valid   (o_cmd_valid),
    .o_cmd         (o_cmd),
    .o_pix_valid   (o_pix_valid),
    .o_pix_data    (o_pix_data),
    .o_x           (o_x),
    .o_y           (o_y),
    .o_frame_start (o_frame_start),
    .o_frame_done  (o_frame_done),
    .o_err         (o_err)
  );

  always @(negedge clk) begin
    if (o_pix_valid) obs_q.push_back({o_pix_data, o_x, o_y, o_frame_done});
    if (o_cmd_valid) cmd_cnt++;
    if (o_frame_start) fs_cnt++;
    if (o_err) err_cnt++;
    if (o_frame_done && !o_pix_valid) stray_done++;
  end

  task automatic spi_bits(input logic dc, input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk);
      sdi  = b[i];
      dcrs = dc;
      repeat (3) @(negedge clk);
      sck = 1'b1;
      repeat (3) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic dc, input logic [7:0] b);
    spi_bits(dc, b, 8);
  endtask

  task automatic send_pixel(input logic [15:0] d);
    spi_byte(1'b1, d[15:8]);
    spi_byte(1'b1, d[7:0]);
  endtask

  task automatic send_window(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e);
    spi_byte(1'b0, cmd);
    spi_byte(1'b1, s[15:8]);
    spi_byte(1'b1, s[7:0]);
    spi_byte(1'b1, e[15:8]);
    spi_byte(1'b1, e[7:0]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_cmd_valid, o_pix_valid, o_frame_start, o_frame_done, o_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes: got %b, want 00000",
               {o_cmd_valid, o_pix_valid, o_frame_start, o_frame_done, o_err});
    end
    checks++;
    if ({o_cmd, o_pix_data, o_x, o_y} !== 41'd0) begin
      failures++;
      $display("FAIL reset_values: got cmd=%h pix=%h x=%0d y=%0d, want all 0", o_cmd, o_pix_data, o_x, o_y);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_first_pixel;
    pix_t e, o;
    int fs0 = fs_cnt;
    spi_byte(1'b0, 8'h2C);
    repeat (8) @(negedge clk);
    checks++;
    if (fs_cnt - fs0 != 1) begin
      failures++;
      $display("FAIL t1_frame_start: got %0d pulses, want 1", fs_cnt - fs0);
    end
    checks++;
    if (o_cmd !== 8'h2C) begin
      failures++;
      $display("FAIL t1_cmd: got %h, want 2c", o_cmd);
    end
    exp_q.push_back({16'hF800, 9'd0, 8'd0, 1'b0});
    send_pixel(16'hF800);
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t1_count: got %0d pixels, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL t1_pix: got d=%h x=%0d y=%0d done=%b, want d=%h x=%0d y=%0d done=%b",
                 o.d, o.x, o.y, o.done, e.d, e.x, e.y, e.done);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_window;
    pix_t e, o;
    int cmd0 = cmd_cnt;
    int err0 = err_cnt;
    logic [8:0] xs_tab[7] = '{9'd10, 9'd11, 9'd12, 9'd10, 9'd11, 9'd12, 9'd10};
    logic [7:0] ys_tab[7] = '{8'd5, 8'd5, 8'd5, 8'd6, 8'd6, 8'd6, 8'd5};
    send_window(8'h2A, 16'h000A, 16'h000C);
    send_window(8'h2B, 16'h0005, 16'h0006);
    spi_byte(1'b0, 8'h2C);
    for (int i = 0; i < 7; i++) begin
      logic [15:0] d;
      d = 16'hA500 + 16'(i * 17);
      exp_q.push_back({d, xs_tab[i], ys_tab[i], (i == 5)});
      send_pixel(d);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (cmd_cnt - cmd0 != 3 || err_cnt != err0) begin
      failures++;
      $display("FAIL t2_cmds: got cmds=%0d errs=%0d, want cmds=3 errs=0", cmd_cnt - cmd0, err_cnt - err0);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t2_count: got %0d pixels, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL t2_pix: got d=%h x=%0d y=%0d done=%b, want d=%h x=%0d y=%0d done=%b",
                 o.d, o.x, o.y, o.done, e.d, e.x, e.y, e.done);
      end
    end
    checks++;
    if (stray_done != 0) begin
      failures++;
      $display("FAIL t2_stray_done: got %0d, want 0", stray_done);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_bad_window;
    pix_t e, o;
    int err0 = err_cnt;
    send_window(8'h2A, 16'h0140, 16'h013F);
    repeat (8) @(negedge clk);
    checks++;
    if (err_cnt - err0 != 1) begin
      failures++;
      $display("FAIL t3_err: got %0d pulses, want 1", err_cnt - err0);
    end
    spi_byte(1'b0, 8'h2C);
    exp_q.push_back({16'h0F0F, 9'd10, 8'd5, 1'b0});
    send_pixel(16'h0F0F);
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL t3_count: got %0d pixels, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL t3_pix: got d=%h x=%0d y=%0d done=%b, want d=%h x=%0d y=%0d done=%b",
                 o.d, o.x, o.y, o.done, e.d, e.x, e.y, e.done);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_partial_byte;
    pix_t e, o;
    int cmd0 = cmd_cnt;
    spi_bits(1'b1, 8'hFF, 5);
    repeat (3) @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    spi_byte(1'b1, 8'h12);
    exp_q.push_back({16'h1234, 9'd11, 8'd5, 1'b0});
    spi_byte(1'b1, 8'h34);
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size() || cmd_cnt != cmd0) begin
      failures++;
      $display("FAIL t4_count: got %0d pixels %0d cmds, want %0d pixels 0 cmds",
               obs_q.size(), cmd_cnt - cmd0, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL t4_pix: got d=%h x=%0d y=%0d done=%b, want d=%h x=%0d y=%0d done=%b",
                 o.d, o.x, o.y, o.done, e.d, e.x, e.y, e.done);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_cmd_abort;
    int cmd0 = cmd_cnt;
    int fs0 = fs_cnt;
    spi_byte(1'b1, 8'h55);
    spi_byte(1'b0, 8'h29);
    repeat (8) @(negedge clk);
    checks++;
    if (o_cmd !== 8'h29 || cmd_cnt - cmd0 != 1) begin
      failures++;
      $display("FAIL t5_cmd: got cmd=%h pulses=%0d, want cmd=29 pulses=1", o_cmd, cmd_cnt - cmd0);
    end
    spi_byte(1'b1, 8'h77);
    spi_byte(1'b1, 8'h88);
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || fs_cnt != fs0) begin
      failures++;
      $display("FAIL t5_no_pixel: got %0d pixels %0d frame starts, want 0 and 0", obs_q.size(), fs_cnt - fs0);
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_pixel;
    pix_t e, o;
    int fs0;
    spi_byte(1'b0, 8'h2C);
    spi_byte(1'b1, 8'h99);
    spi_bits(1'b1, 8'hF0, 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sck = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_cmd, o_pix_data, o_x, o_y} !== 41'd0) begin
      failures++;
      $display("FAIL t6_reset_values: got cmd=%h pix=%h x=%0d y=%0d, want all 0", o_cmd, o_pix_data, o_x, o_y);
    end
    repeat (4) @(negedge clk);
    obs_q.delete();
    fs0 = fs_cnt;
    spi_byte(1'b0, 8'h2C);
    exp_q.push_back({16'hABCD, 9'd0, 8'd0, 1'b0});
    send_pixel(16'hABCD);
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size() || fs_cnt - fs0 != 1) begin
      failures++;
      $display("FAIL t6_count: got %0d pixels %0d starts, want %0d pixels 1 start",
               obs_q.size(), fs_cnt - fs0, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL t6_pix: got d=%h x=%0d y=%0d done=%b, want d=%h x=%0d y=%0d done=%b",
                 o.d, o.x, o.y, o.done, e.d, e.x, e.y, e.done);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_pixel();
    test_window();
    test_bad_window();
    test_partial_byte();
    test_cmd_abort();
    test_reset_mid_pixel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
